pipe_addsub: RTL and testbench
==============================

// Module: pipe_addsub
// PURPOSE
//  Pipelined, parametrised ripple-carry adder/subtractor. The IP_WIDTH-bit carry
//  chain is cut into STAGES equal slices, with one register boundary per slice,
//  so wide adds close timing at full clock rate. It adds a per-operation
//  add/sub mode, a signed overflow flag and a valid/ready handshake on both
//  sides, so it drops straight into streaming datapaths.
// PARAMETERS
//  IP_WIDTH  32  operand/result width in bits; must be >= 1
//  STAGES    4   pipeline depth = number of carry slices; 1..IP_WIDTH, must divide IP_WIDTH
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         async active-low reset
//  in_valid   in   1         input beat present
//  in_ready   out  1         block accepts the beat this cycle
//  a          in   IP_WIDTH  operand A
//  b          in   IP_WIDTH  operand B
//  c_in       in   1         carry-in (add) / borrow-in (sub)
//  sub        in   1         0: a+b+c_in   1: a-b-c_in
//  out_valid  out  1         result beat present
//  out_ready  in   1         downstream accepts the result
//  sum        out  IP_WIDTH  result, modulo 2^IP_WIDTH
//  c_out      out  1         carry-out (add) / NOT borrow-out (sub)
//  ovf        out  1         two's-complement signed overflow
// BEHAVIOUR
//  - Slice width W = IP_WIDTH/STAGES. Stage k (0..STAGES-1) computes result bits
//    [k*W +: W] from the carry that stage k-1 registered. Unconsumed upper operand
//    slices and already-computed lower sum slices are carried forward (skewed)
//    in the stage registers.
//  - Operation at stage 0: B' = sub ? ~b : b; cin' = sub ? ~c_in : c_in.
//    result = a + B' + cin'. c_out is the carry out of bit IP_WIDTH-1.
//    ovf = (a[MSB] == B'[MSB]) && (sum[MSB] != a[MSB]).
//  - Each stage k has a valid bit v[k]. Define rdy[STAGES] = out_ready and
//    rdy[k] = !v[k] || rdy[k+1]. in_ready = rdy[0].
//  - Stage k loads when rdy[k] is high. The load source is the input for k=0,
//    otherwise stage k-1. v[k] takes the upstream valid: in_valid for k=0,
//    otherwise v[k-1].
//  - Handshake: transfer happens on valid && ready at the clock edge. Ready is
//    combinational from out_ready and the v bits; it never depends on in_valid.
//  - Latency: STAGES cycles from input transfer to out_valid when out_ready=1.
//    Throughput is 1 beat/clk.
//  - Bubbles collapse: an empty stage accepts data even while out_ready=0.
//  - Backpressure: while out_valid && !out_ready, sum/c_out/ovf/out_valid hold stable.
//    Up to STAGES beats are held; in_ready falls only when all stages are full and
//    out_ready=0.
//  - Simultaneous accept and emit with a full pipe and out_ready=1 is lossless;
//    beats shift one stage.
//  - out_valid = v[STAGES-1]. sum/c_out/ovf are registers of the last stage, not
//    combinational.
//  - Data registers load only when their stage loads, and only while the incoming
//    beat is valid.
//  - Reset (async assert, sync deassert handled externally): all v[k]=0, every data
//    register = 0. So out_valid=0, sum=0, c_out=0, ovf=0, and in_ready=1 during and
//    after reset.
//  - Reset asserted mid-stream drops all in-flight beats. No partial result is
//    emitted after release.
//  - STAGES=1 degenerates to a single registered adder, latency 1.
//  - STAGES=IP_WIDTH gives a 1-bit slice per stage.
//  - Ordering is strictly FIFO. No beat is duplicated or dropped except by reset.
// TESTING (IP_WIDTH=8, STAGES=2 unless noted)
//  1. Reset: hold rst_n=0 -> out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1.
//  2. Add with carry across the slice boundary: a=0x0F, b=0x01, c_in=0, sub=0,
//     out_ready=1 -> 2 clk later sum=0x10, c_out=0, ovf=0.
//     Then a=0x7F, b=0x01 -> sum=0x80, ovf=1.
//  3. Subtract: a=0x05, b=0x07, c_in=0, sub=1 -> sum=0xFE, c_out=0, ovf=0.
//     Then a=0x80, b=0x01, sub=1 -> sum=0x7F, c_out=1, ovf=1.
//  4. Backpressure: stream 4 beats with out_ready=0 -> in_ready falls after 2
//     accepts and the output holds beat 0. Release out_ready -> beats emerge in
//     order, none lost or duplicated.
//  5. Full rate: 256 random beats with in_valid=1 and out_ready=1 -> one result
//     per clk, each matching a +/- b +/- c_in modulo 256 with correct c_out/ovf.
//     Repeat for STAGES=1, 4 and 8.
//  6. Reset mid-flight: assert rst_n=0 with 2 beats in the pipe -> out_valid=0
//     immediately (async). After release, no stale beat appears and a new beat
//     has latency 2.

Source files
------------

// File: rtl/pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// The carry chain is cut into STAGES equal slices; each stage keeps only the operand bits still to be added and the sum bits already produced.
module pipe_addsub #(
    parameter int IP_WIDTH = 32,
    parameter int STAGES   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IP_WIDTH-1:0] a,
    input  logic [IP_WIDTH-1:0] b,
    input  logic                c_in,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IP_WIDTH-1:0] sum,
    output logic                c_out,
    output logic                ovf
);

    localparam int W       = IP_WIDTH / STAGES;
    localparam int FWD_TOT = W * STAGES * (STAGES - 1) / 2;
    localparam int FWD_W   = (FWD_TOT > 0) ? FWD_TOT : 1;
    localparam int SUM_W   = W * STAGES * (STAGES + 1) / 2;

    // Bit offsets of each stage's skewed operand / sum registers in the flat buses.
    function automatic int fwd_off(input int k);
        return W * (k * STAGES - (k * (k + 1)) / 2);
    endfunction

    function automatic int sum_off(input int k);
        return W * ((k * (k + 1)) / 2);
    endfunction

    logic [FWD_W-1:0]  fwd_a;
    logic [FWD_W-1:0]  fwd_b;
    logic [SUM_W-1:0]  sum_bus;
    logic [STAGES-1:0] c_bus;
    logic [STAGES-1:0] v_bus;
    logic [STAGES:0]   rdy;

    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];
    assign out_valid   = v_bus[STAGES-1];
    assign c_out       = c_bus[STAGES-1];
    assign sum         = sum_bus[sum_off(STAGES-1) +: IP_WIDTH];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int IN_W = IP_WIDTH - k * W;
        localparam int LO_W = k * W;

        logic [IN_W-1:0]      src_a;
        logic [IN_W-1:0]      src_b;
        logic                 src_c;
        logic                 src_v;
        logic [W:0]           slice;
        logic [LO_W+W-1:0]    sum_d;
        logic [LO_W+W-1:0]    sum_q;
        logic                 c_q;
        logic                 v_q;

        assign rdy[k] = !v_q || rdy[k+1];

        if (k == 0) begin : g_src
            // Subtraction is a + ~b + ~c_in, so borrow-in inverts like b.
            assign src_a = a;
            assign src_b = sub ? ~b : b;
            assign src_c = sub ^ c_in;
            assign src_v = in_valid;
            assign sum_d = slice[W-1:0];
        end else begin : g_src
            localparam int FO = fwd_off(k - 1);
            localparam int SO = sum_off(k - 1);
            assign src_a = fwd_a[FO +: IN_W];
            assign src_b = fwd_b[FO +: IN_W];
            assign src_c = c_bus[k-1];
            assign src_v = v_bus[k-1];
            assign sum_d = {slice[W-1:0], sum_bus[SO +: LO_W]};
        end

        assign slice = {1'b0, src_a[W-1:0]} + {1'b0, src_b[W-1:0]} + {{W{1'b0}}, src_c};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (rdy[k]) begin
                v_q <= src_v;
                if (src_v) begin
                    sum_q <= sum_d;
                    c_q   <= slice[W];
                end
            end
        end

        assign sum_bus[sum_off(k) +: LO_W + W] = sum_q;
        assign c_bus[k] = c_q;
        assign v_bus[k] = v_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [IN_W-W-1:0] a_q;
            logic [IN_W-W-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (rdy[k] && src_v) begin
                    a_q <= src_a[IN_W-1:W];
                    b_q <= src_b[IN_W-1:W];
                end
            end

            assign fwd_a[fwd_off(k) +: IN_W-W] = a_q;
            assign fwd_b[fwd_off(k) +: IN_W-W] = b_q;
        end else begin : g_last
            logic ovf_q;

            // The operand MSBs are consumed here, so signed overflow is resolved in the last stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (rdy[k] && src_v) begin
                    ovf_q <= (src_a[W-1] == src_b[W-1]) && (slice[W-1] != src_a[W-1]);
                end
            end

            assign ovf = ovf_q;
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed vectors, backpressure, mid-flight reset and random full-rate streams.
// Instance 0 uses STAGES=2; instances 1..3 use STAGES=1, 4, 8 for the random streams.
module tb_pipe_addsub;
    localparam int N  = 8;
    localparam int NI = 4;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sb;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       c_in = 1'b0;
    logic       sub = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    logic       in_ready_s [NI];
    logic       out_valid_s[NI];
    logic       c_out_s    [NI];
    logic       ovf_s      [NI];
    logic [7:0] sum_s      [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic int st_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pipe_addsub #(.IP_WIDTH(N), .STAGES(st_of(g))) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready_s[g]),
            .a        (a),
            .b        (b),
            .c_in     (c_in),
            .sub      (sub),
            .out_valid(out_valid_s[g]),
            .out_ready(out_ready),
            .sum      (sum_s[g]),
            .c_out    (c_out_s[g]),
            .ovf      (ovf_s[g])
        );
    end

    // Reference: exact integer arithmetic, unsigned for carry and signed for overflow.
    function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                         input logic ci, input logic sb);
        int ua, ub, sa, sbv, civ, ur, sr;
        logic co, ov;
        logic [7:0] s;
        ua  = int'(av);
        ub  = int'(bv);
        sa  = int'($signed(av));
        sbv = int'($signed(bv));
        civ = ci ? 1 : 0;
        if (!sb) begin
            ur = ua + ub + civ;
            sr = sa + sbv + civ;
            co = (ur > 255);
        end else begin
            ur = ua - ub - civ;
            sr = sa - sbv - civ;
            co = (ur >= 0);
        end
        s  = ur[7:0];
        ov = (sr > 127) || (sr < -128);
        return {s, co, ov};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with instance 0 empty or draining.
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        a = v.a; b = v.b; c_in = v.ci; sub = v.sb;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_s[0] && lat < 10) begin
            cyc();
            lat++;
        end
        chk({nm, "_latency"}, lat, 2);
        chk({nm, "_sum"}, int'(sum_s[0]), int'(v.s));
        chk({nm, "_cout"}, int'(c_out_s[0]), int'(v.co));
        chk({nm, "_ovf"}, int'(ovf_s[0]), int'(v.ov));
        cyc();
    endtask

    vec_t vt[8];
    vec_t vnew;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] bp_a[4];
        logic [7:0] got[$];
        logic [9:0] ex[256];
        int acc, stale;
        int rd[NI], first[NI], last[NI], notrdy[NI];
        logic fire_in, fire_out;

        vt[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vt[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vt[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vt[4] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vt[7] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

        // Reset state
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 8'h55; b = 8'h33;
        cyc(); cyc(); cyc();
        chk("rst_out_valid", int'(out_valid_s[0]), 0);
        chk("rst_sum", int'(sum_s[0]), 0);
        chk("rst_cout", int'(c_out_s[0]), 0);
        chk("rst_ovf", int'(ovf_s[0]), 0);
        chk("rst_in_ready", int'(in_ready_s[0]), 1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_in_ready", int'(in_ready_s[0]), 1);

        // Directed vectors
        for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Backpressure with four beats
        bp_a[0] = 8'h11; bp_a[1] = 8'h22; bp_a[2] = 8'h33; bp_a[3] = 8'h44;
        b = 8'h01; sub = 1'b0; c_in = 1'b0;
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            a = bp_a[acc];
            in_valid = 1'b1;
            #1;
            fire_in = in_ready_s[0];
            @(posedge clk); #1;
            if (fire_in) acc++;
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready_low", int'(in_ready_s[0]), 0);
        chk("bp_out_valid", int'(out_valid_s[0]), 1);
        chk("bp_head_sum", int'(sum_s[0]), 8'h12);
        for (int c = 0; c < 2; c++) begin
            cyc();
            chk($sformatf("bp_hold%0d_sum", c), int'(sum_s[0]), 8'h12);
            chk($sformatf("bp_hold%0d_valid", c), int'(out_valid_s[0]), 1);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            in_valid = (acc < 4);
            a = bp_a[(acc < 4) ? acc : 3];
            #1;
            fire_in  = in_valid && in_ready_s[0];
            fire_out = out_valid_s[0] && out_ready;
            if (fire_out) got.push_back(sum_s[0]);
            @(posedge clk); #1;
            if (fire_in) acc++;
        end
        in_valid = 1'b0;
        chk("bp_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size())
                chk($sformatf("bp_order%0d", i), int'(got[i]), int'(bp_a[i]) + 1);
        end
        cyc(); cyc();
        chk("bp_no_duplicate", int'(out_valid_s[0]), 0);

        // Reset with two beats in flight
        out_ready = 1'b1;
        a = 8'h21; b = 8'h03; sub = 1'b0; c_in = 1'b0;
        in_valid = 1'b1;
        cyc();
        a = 8'h31;
        cyc();
        in_valid = 1'b0;
        chk("mid_pre_valid", int'(out_valid_s[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_valid", int'(out_valid_s[0]), 0);
        chk("mid_async_sum", int'(sum_s[0]), 0);
        chk("mid_in_ready", int'(in_ready_s[0]), 1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid_s[0]) stale++;
            cyc();
        end
        chk("mid_no_stale", stale, 0);
        vnew = '{8'h40, 8'h02, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0};
        run_vec(vnew, "mid_new");

        // Full-rate random streams on all depths
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        for (int g = 0; g < NI; g++) begin
            rd[g] = 0; first[g] = -1; last[g] = -1; notrdy[g] = 0;
        end
        for (int c = 0; c < 256 + 12; c++) begin
            if (c < 256) begin
                a = 8'($urandom);
                b = 8'($urandom);
                c_in = 1'($urandom);
                sub = 1'($urandom);
                in_valid = 1'b1;
                ex[c] = model(a, b, c_in, sub);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            for (int g = 0; g < NI; g++) begin
                if (!in_ready_s[g]) notrdy[g]++;
                if (out_valid_s[g]) begin
                    if (rd[g] < 256)
                        chk($sformatf("rand_s%0d_beat%0d", st_of(g), rd[g]),
                            int'({sum_s[g], c_out_s[g], ovf_s[g]}), int'(ex[rd[g]]));
                    if (first[g] < 0) first[g] = c;
                    last[g] = c;
                    rd[g]++;
                end
            end
            @(posedge clk); #1;
        end
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rand_s%0d_count", st_of(g)), rd[g], 256);
            chk($sformatf("rand_s%0d_latency", st_of(g)), first[g], st_of(g));
            chk($sformatf("rand_s%0d_contiguous", st_of(g)), last[g] - first[g] + 1, 256);
            chk($sformatf("rand_s%0d_notready", st_of(g)), notrdy[g], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
